twiddle_rd_sched: RTL and testbench

Read scheduler for the three-bank radix-4 twiddle ROM in the merged DIT FFT4 datapath. For each FFT stage, it sequences the shared 11-bit ROM address and the read-enable strobe. It also produces a valid/last stream that is aligned with the ROM's one-cycle read latency. The stream honours backpressure from the butterfly, so the butterfly never loses a 3×256-bit twiddle word.

---
 rtl/fft_tw_pkg.sv | 10 +
 rtl/twiddle_rd_sched.sv | 104 ++++++++++
 tb/tb_twiddle_rd_sched.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fft_tw_pkg.sv
// fft_tw_pkg: shared twiddle-ROM constants, scheduler state enum and stage base helper
package fft_tw_pkg;
  localparam int TW_ADDR_W = 11;
  localparam int TW_NUM_STAGES = 6;
  localparam int TW_WORDS_PER_STAGE = 256;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} tw_sched_state_e;
  function automatic int tw_stage_base(input logic [2:0] stage, input int words = TW_WORDS_PER_STAGE);
    return 32'(stage) * words;
  endfunction
endpackage

// File: rtl/twiddle_rd_sched.sv
// twiddle_rd_sched: per-stage read sequencer for the radix-4 twiddle ROM with a 1-deep valid/last stream
// Ports: clk, rst_n (sync, active-low); start_i/stage_i launch a stage, abort_i abandons it;
//   tw_ready_i is butterfly backpressure; rom_valid_o/rom_addr_o drive the ROM;
//   tw_valid_o/tw_last_o qualify ROM data; busy_o, done_o and err_o report status.
// Build option: TW_STAGE0_BYPASS_EN makes stage 0 finish immediately without ROM reads.
module twiddle_rd_sched
  import fft_tw_pkg::*;
#(
  parameter int ADDR_W = TW_ADDR_W,
  parameter int NUM_STAGES = TW_NUM_STAGES,
  parameter int WORDS_PER_STAGE = TW_WORDS_PER_STAGE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [2:0]        stage_i,
  input  logic              abort_i,
  input  logic              tw_ready_i,
  output logic              rom_valid_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              tw_valid_o,
  output logic              tw_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int CW = $clog2(WORDS_PER_STAGE);
  localparam logic [CW-1:0] CNT_MAX = CW'(WORDS_PER_STAGE - 1);
  if (NUM_STAGES * WORDS_PER_STAGE > 2 ** ADDR_W) begin : g_range_chk
    $error("twiddle tables exceed ROM address space");
  end
  tw_sched_state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0] stage, stage_d;
  logic valid_d, last_d, done_d, err_d, accept;
  assign rom_addr_o = ADDR_W'(tw_stage_base(stage, WORDS_PER_STAGE)) + ADDR_W'(cnt);
  assign busy_o = state != IDLE;
  assign accept = tw_valid_o & tw_ready_i;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      stage <= '0;
      tw_valid_o <= 1'b0;
      tw_last_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      stage <= stage_d;
      tw_valid_o <= valid_d;
      tw_last_o <= last_d;
      done_o <= done_d;
      err_o <= err_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    stage_d = stage;
    done_d = 1'b0;
    err_d = 1'b0;
    rom_valid_o = (state == RUN) & (~tw_valid_o | tw_ready_i);
    valid_d = accept ? 1'b0 : tw_valid_o;
    last_d = accept ? 1'b0 : tw_last_o;
    if (rom_valid_o) begin
      valid_d = 1'b1;
      last_d = cnt == CNT_MAX;
      cnt_d = cnt + CW'(1);
      state_d = (cnt == CNT_MAX) ? DRAIN : RUN;
    end
    if (state == IDLE && start_i) begin
      if (32'(stage_i) >= NUM_STAGES) err_d = 1'b1;
`ifdef TW_STAGE0_BYPASS_EN
      else if (stage_i == 3'd0) begin
        state_d = DRAIN;
        done_d = 1'b1;
      end
`endif
      else begin
        stage_d = stage_i;
        cnt_d = '0;
        state_d = RUN;
      end
    end
    if (state == DRAIN && accept && tw_last_o) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
`ifdef TW_STAGE0_BYPASS_EN
    // a bypassed stage 0 parks in DRAIN for one cycle with nothing outstanding
    if (state == DRAIN && !tw_valid_o) state_d = IDLE;
`endif
    if (abort_i) begin
      state_d = IDLE;
      cnt_d = '0;
      valid_d = 1'b0;
      last_d = 1'b0;
      done_d = 1'b0;
      err_d = 1'b0;
    end
  end
endmodule

// File: tb/tb_twiddle_rd_sched.sv
// tb_twiddle_rd_sched: randomized self-checking bench for twiddle_rd_sched against a word-level stream model
module tb_twiddle_rd_sched;
  localparam int WPS = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic [2:0] stage_i = '0;
  logic abort_i = 1'b0;
  logic tw_ready_i = 1'b0;
  logic rom_valid_o, tw_valid_o, tw_last_o, busy_o, done_o, err_o;
  logic [10:0] rom_addr_o;
  int checks = 0;
  int errors = 0;
  twiddle_rd_sched dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stage_i(stage_i), .abort_i(abort_i),
    .tw_ready_i(tw_ready_i), .rom_valid_o(rom_valid_o), .rom_addr_o(rom_addr_o),
    .tw_valid_o(tw_valid_o), .tw_last_o(tw_last_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_rom_valid"}, rom_valid_o, 0);
    check({tag, "_rom_addr"}, rom_addr_o, 0);
    check({tag, "_tw_valid"}, tw_valid_o, 0);
    check({tag, "_tw_last"}, tw_last_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask
  // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1; mode 2: random ready
  task automatic run_stage(input int s, input int mode, input int abort_at, input int glitch_at);
    int issued = 0;
    int accepted = 0;
    int n = 1;
    int ready;
    bit mv = 0;
    bit exp_rv;
    bit done_exp = 0;
    bit done_next = 0;
    bit finished = 0;
    int base = s * WPS;
    start_i = 1'b1;
    stage_i = 3'(s);
    next_cycle();
    start_i = 1'b0;
    while (!finished && n < 3000) begin
      if (abort_at >= 0 && issued == abort_at) begin
        abort_i = 1'b1;
        tw_ready_i = 1'($urandom_range(0, 1));
        next_cycle();
        abort_i = 1'b0;
        @(negedge clk);
        check("abort_busy", busy_o, 0);
        check("abort_tw_valid", tw_valid_o, 0);
        check("abort_tw_last", tw_last_o, 0);
        check("abort_rom_valid", rom_valid_o, 0);
        for (int i = 0; i < 4; i++) begin
          check("abort_no_done", done_o, 0);
          next_cycle();
          @(negedge clk);
        end
        return;
      end
      ready = mode == 0 ? 1 : mode == 1 ? ((n % 4 == 1 || n % 4 == 0) ? 1 : 0) : int'($urandom_range(0, 1));
      tw_ready_i = 1'(ready);
      start_i = (glitch_at == n);
      stage_i = 3'((s + 1) % 6);
      @(negedge clk);
      done_exp = done_next;
      check("done", done_o, done_exp);
      check("busy", busy_o, !done_exp);
      if (done_exp) begin
        if (mode == 0) check("done_latency", n, WPS + 2);
        finished = 1;
      end else begin
        exp_rv = issued < WPS && (!mv || ready == 1);
        check("rom_valid", rom_valid_o, exp_rv);
        check("tw_valid", tw_valid_o, mv);
        if (issued < WPS) check("rom_addr", rom_addr_o, base + issued);
        if (mv && ready == 1) begin
          check("tw_last", tw_last_o, accepted == WPS - 1);
          accepted++;
          done_next = accepted == WPS;
        end
        mv = exp_rv || (mv && ready == 0);
        if (exp_rv) issued++;
        next_cycle();
        n++;
      end
    end
    start_i = 1'b0;
    if (!finished) check("stage_timeout", 0, 1);
    check("accept_count", accepted, WPS);
  endtask
  task automatic bad_stage(input int s);
    start_i = 1'b1;
    stage_i = 3'(s);
    next_cycle();
    start_i = 1'b0;
    @(negedge clk);
    check("err_pulse", err_o, 1);
    check("err_busy", busy_o, 0);
    check("err_rom_valid", rom_valid_o, 0);
    next_cycle();
    @(negedge clk);
    check("err_clear", err_o, 0);
    check("err_busy2", busy_o, 0);
    check("err_rom_valid2", rom_valid_o, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    next_cycle();
    run_stage(2, 0, -1, -1);
    run_stage(1, 1, -1, -1);
    bad_stage(6);
    bad_stage(7);
    run_stage(3, 2, 100, -1);
    run_stage(3, 2, -1, -1);
    run_stage(5, 0, -1, 60);
`ifdef TW_STAGE0_BYPASS_EN
    start_i = 1'b1;
    stage_i = 3'd0;
    next_cycle();
    start_i = 1'b0;
    @(negedge clk);
    check("byp_done", done_o, 1);
    check("byp_busy", busy_o, 1);
    check("byp_rom_valid", rom_valid_o, 0);
    check("byp_tw_valid", tw_valid_o, 0);
    next_cycle();
    @(negedge clk);
    check("byp_done_clear", done_o, 0);
    check("byp_busy_clear", busy_o, 0);
    check("byp_rom_valid2", rom_valid_o, 0);
`else
    run_stage(0, 0, -1, -1);
`endif
    for (int k = 0; k < 3; k++) run_stage(int'($urandom_range(1, 5)), 2, -1, -1);
    start_i = 1'b1;
    stage_i = 3'd4;
    tw_ready_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    for (int i = 0; i < 20; i++) next_cycle();
    rst_n = 1'b0;
    next_cycle();
    @(negedge clk);
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("midreset_no_done", done_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
